cpu_out_sink: RTL and testbench
===============================

# cpu_out_sink

Receiving end of the CPU output port. Captures every word the CPU presents on `outFlag`/`out` into a small FIFO and hands the words to a host-side consumer (bench monitor, UART bridge, logic analyser) over a valid/ready interface. Drops are detected, counted, and flagged instead of stalling the CPU, which has no backpressure.

## Interface
Parameters:
- `WIDTH`, 16, data width. Matches the CPU datapath width.
- `DEPTH`, 8, FIFO entries. Must be a power of two and at least 2.
- `DROPW`, 8, width of the saturating drop counter.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `outFlag`  in  1  CPU output strobe. Each cycle it is high, one word is written.
- `out`  in  WIDTH  CPU output word; valid when `outFlag` is high.
- `rd_valid`  out  1  FIFO head holds a word.
- `rd_data`  out  WIDTH  head word; stable while `rd_valid` is high and `rd_ready` is low.
- `rd_ready`  in  1  consumer accepts the head word this cycle.
- `count`  out  $clog2(DEPTH+1)  current occupancy, 0 to DEPTH.
- `full`  out  1  `count` equals DEPTH.
- `overflow`  out  1  sticky; set when a word was dropped.
- `drop_count`  out  DROPW  number of dropped words; saturates at all-ones.
- `clear_ovf`  in  1  clears `overflow` and `drop_count`.

## Operation
- **Push:** `outFlag` high at an edge. The word is written at the write pointer, the pointer increments, and it wraps modulo DEPTH.
- **Pop:** `rd_valid && rd_ready` at an edge. The read pointer increments and wraps modulo DEPTH. When empty, `rd_ready` is ignored and no underflow occurs.
- **Show-ahead output:** `rd_data` always reflects the entry at the read pointer. `rd_valid = (count != 0)`.
- **Simultaneous push and pop:**
  - The push is accepted even when full.
  - `count` is unchanged.
  - No drop is recorded.
- **Push when full without a pop:**
  - The word is discarded and FIFO contents are unchanged.
  - `overflow` is set to 1.
  - `drop_count` increments unless it is already all-ones.
- **`clear_ovf` timing:**
  - `clear_ovf` high at an edge sets `overflow` to 0 and `drop_count` to 0.
  - If a drop occurs in the same cycle, clear wins for that edge. The drop is not counted.
- **Arithmetic:**
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally.
  - `count` is tracked explicitly: +1 on push-only, -1 on pop-only, unchanged otherwise.
- **No bypass:** a word pushed into an empty FIFO is not visible in the same cycle.

## Timing
- **Reset values:**
  - `rd_valid`=0, `count`=0, `full`=0, `overflow`=0, `drop_count`=0.
  - Pointers are 0.
  - `rd_data` is don't-care while `rd_valid`=0. Storage is not cleared.
- **Reset mid-operation:** on the reset edge, all buffered words are discarded. `outFlag` and `rd_ready` are ignored on that edge.
- **Latency:** a word with `outFlag` high at edge k gives `rd_valid`=1 with that word on `rd_data` in the cycle after edge k.
- **Throughput:** sustained one push and one pop per cycle with occupancy held constant.
- **Output registration:**
  - `full`, `overflow`, and `drop_count` are registered or derived from registers only.
  - There is no combinational path from `outFlag` or `rd_ready` to any output.
- **Memory type:** storage is an inferred register array with a combinational read from the read pointer. It can be implemented as distributed RAM or flops.

## Structure
- **Shared package:** the CPU package carries the data-width constant. The default of `WIDTH` is taken from it so that both ends of the port share one definition.
- **`sync_fifo` sub-module** (parameters WIDTH, DEPTH): storage, pointers, and count, with push, pop, full, and empty.
- **Wrapper `cpu_out_sink`:**
  - Maps `outFlag` to push and `rd_valid && rd_ready` to pop.
  - Owns `overflow` and `drop_count`.
  - Computes the dropped-word condition as `outFlag && full && !pop`.

## Test plan
All scenarios use DEPTH=4 and DROPW=4.
- **Reset then single word:**
  - Stimulus: reset for 1 edge, then `outFlag`=1 with `out`=16'h00A5 for 1 cycle, `rd_ready`=0.
  - Expected: next cycle `rd_valid`=1, `rd_data`=16'h00A5, `count`=1. Pulse `rd_ready` and `count` returns to 0.
- **Ordering and wrap:**
  - Stimulus: push 1,2,3,4, pop 2, push 5,6, then pop all.
  - Expected: consumer sees 1,2,3,4,5,6 in order. Both pointers have wrapped. `overflow`=0.
- **Overflow:**
  - Stimulus: with `rd_ready`=0, push 10,11,12,13,14,15.
  - Expected: `full`=1 after the 4th push. `overflow`=1 and `drop_count`=2. Draining yields 10,11,12,13.
- **Push and pop while full:**
  - Stimulus: fill with 1 to 4, then assert `outFlag`=1 (`out`=9) and `rd_ready`=1 in the same cycle.
  - Expected: `count` stays 4, no drop recorded. Drain yields 2,3,4,9.
- **Saturation and clear:**
  - Stimulus: hold a full FIFO and push 20 more words, then assert `clear_ovf` for 1 cycle.
  - Expected: `drop_count` stops at 4'hF. After the clear, `overflow`=0 and `drop_count`=0, with FIFO contents intact.
- **Reset mid-operation:**
  - Stimulus: 3 words buffered, assert `reset` for 1 edge with `outFlag`=1 on that edge.
  - Expected: `count`=0, `rd_valid`=0, and the push is ignored.

Source files
------------

// File: rtl/cpu_out_sink_pkg.sv
// cpu_out_sink_pkg: data-width constant shared by both ends of the CPU output port
package cpu_out_sink_pkg;
    localparam int CPU_WIDTH = 16;
endpackage

// File: rtl/cpu_out_sink_sync_fifo.sv
// sync_fifo: show-ahead register-array FIFO with explicit occupancy count
module sync_fifo
    import cpu_out_sink_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr, rd;
    always_comb begin
        rd = pop && !empty;
        wr = push && (!full || rd);
    end
    always_ff @(posedge clock)
        if (!reset && wr) mem[wp] <= din;
    always_ff @(posedge clock) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            count <= (wr && !rd) ? count + 1'b1 : (rd && !wr) ? count - 1'b1 : count;
        end
    end
    assign dout = mem[rp];
    assign full = count == FULL_CNT;
    assign empty = count == '0;
endmodule

// File: rtl/cpu_out_sink.sv
// cpu_out_sink: buffers CPU output words for a valid/ready consumer, flagging and counting drops
module cpu_out_sink
    import cpu_out_sink_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH,
    parameter int DEPTH = 8,
    parameter int DROPW = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       outFlag,
    input  logic [WIDTH-1:0]           out,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow,
    output logic [DROPW-1:0]           drop_count,
    input  logic                       clear_ovf
);
    logic empty, pop, drop;
    assign rd_valid = !empty;
    assign pop = rd_valid && rd_ready;
    assign drop = outFlag && full && !pop;
    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(outFlag),
        .pop(pop),
        .din(out),
        .dout(rd_data),
        .count(count),
        .full(full),
        .empty(empty)
    );
    // clear takes priority over a same-cycle drop
    always_ff @(posedge clock) begin
        if (reset || clear_ovf) begin
            overflow <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_count <= &drop_count ? drop_count : drop_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_out_sink.sv
// tb_cpu_out_sink: directed self-checking bench for cpu_out_sink at DEPTH=4, DROPW=4
module tb_cpu_out_sink;
    logic clock = 0;
    logic reset, outFlag, rd_ready, clear_ovf;
    logic [15:0] out, rd_data;
    logic rd_valid, full, overflow;
    logic [2:0] count;
    logic [3:0] drop_count;
    int n_checks = 0;
    int n_errors = 0;

    cpu_out_sink #(.WIDTH(16), .DEPTH(4), .DROPW(4)) dut (
        .clock(clock),
        .reset(reset),
        .outFlag(outFlag),
        .out(out),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_ready(rd_ready),
        .count(count),
        .full(full),
        .overflow(overflow),
        .drop_count(drop_count),
        .clear_ovf(clear_ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        outFlag = 1;
        out = v;
        tick();
        outFlag = 0;
    endtask

    task automatic pop_exp(input logic [15:0] v);
        chk("pop_valid", 32'(rd_valid), 1);
        chk("pop_data", 32'(rd_data), 32'(v));
        rd_ready = 1;
        tick();
        rd_ready = 0;
    endtask

    initial begin
        reset = 1; outFlag = 0; rd_ready = 0; clear_ovf = 0; out = '0;
        tick();
        reset = 0;
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_count), 0);

        // single word, then pop on empty is ignored
        push(16'h00A5);
        chk("one_valid", 32'(rd_valid), 1);
        chk("one_data", 32'(rd_data), 32'h00A5);
        chk("one_count", 32'(count), 1);
        rd_ready = 1;
        tick();
        chk("one_popped", 32'(count), 0);
        tick();
        rd_ready = 0;
        chk("underflow_count", 32'(count), 0);
        chk("underflow_valid", 32'(rd_valid), 0);

        // ordering and pointer wrap
        for (int i = 1; i <= 4; i++) push(16'(i));
        chk("wrap_full", 32'(full), 1);
        pop_exp(1);
        pop_exp(2);
        push(5);
        push(6);
        chk("wrap_count", 32'(count), 4);
        for (int i = 3; i <= 6; i++) pop_exp(16'(i));
        chk("wrap_empty", 32'(count), 0);
        chk("wrap_ovf", 32'(overflow), 0);

        // overflow with no consumer
        for (int i = 10; i <= 15; i++) begin
            push(16'(i));
            if (i == 13) chk("ovf_full4", 32'(full), 1);
            if (i == 13) chk("ovf_none_yet", 32'(overflow), 0);
        end
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drop", 32'(drop_count), 2);
        chk("ovf_count", 32'(count), 4);
        for (int i = 10; i <= 13; i++) pop_exp(16'(i));
        chk("ovf_sticky", 32'(overflow), 1);
        clear_ovf = 1;
        tick();
        clear_ovf = 0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_drop", 32'(drop_count), 0);

        // push and pop in the same cycle while full
        for (int i = 1; i <= 4; i++) push(16'(i));
        outFlag = 1; out = 9; rd_ready = 1;
        tick();
        outFlag = 0; rd_ready = 0;
        chk("pp_count", 32'(count), 4);
        chk("pp_drop", 32'(drop_count), 0);
        chk("pp_ovf", 32'(overflow), 0);
        pop_exp(2);
        pop_exp(3);
        pop_exp(4);
        pop_exp(9);

        // saturation, then clear beating a simultaneous drop
        for (int i = 0; i < 4; i++) push(16'(30 + i));
        for (int i = 0; i < 20; i++) push(16'(100 + i));
        chk("sat_drop", 32'(drop_count), 15);
        chk("sat_ovf", 32'(overflow), 1);
        clear_ovf = 1; outFlag = 1; out = 16'h0099;
        tick();
        clear_ovf = 0; outFlag = 0;
        chk("satclr_ovf", 32'(overflow), 0);
        chk("satclr_drop", 32'(drop_count), 0);
        chk("satclr_count", 32'(count), 4);
        for (int i = 0; i < 4; i++) pop_exp(16'(30 + i));

        // reset mid-operation ignores the push on that edge
        push(16'h0041);
        push(16'h0042);
        push(16'h0043);
        chk("mid_count3", 32'(count), 3);
        reset = 1; outFlag = 1; out = 16'h0077;
        tick();
        reset = 0; outFlag = 0;
        chk("mid_count", 32'(count), 0);
        chk("mid_valid", 32'(rd_valid), 0);
        chk("mid_full", 32'(full), 0);
        tick();
        chk("mid_after", 32'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
